// File: rtl/imem_port_arb_if.sv
// Requester-side bundle of the instruction-memory read port arbiter:
// per-requester request/address in, grant/response/starvation flags out.
interface imem_port_arb_if #(
  parameter int IMEM_W = 13
);
  logic [2:0]        req;
  logic [IMEM_W-1:0] addr0;
  logic [IMEM_W-1:0] addr1;
  logic [IMEM_W-1:0] addr2;
  logic [2:0]        gnt;
  logic [2:0]        rvalid;
  logic [31:0]       rdata;
  logic [2:0]        starved;

  modport master (
    output req, addr0, addr1, addr2,
    input  gnt, rvalid, rdata, starved
  );

  modport slave (
    input  req, addr0, addr1, addr2,
    output gnt, rvalid, rdata, starved
  );
endinterface

// File: rtl/imem_port_arb.sv
// Three-way arbiter for the instruction memory read port: fixed priority with aging.
// Optional grant statistics counters are enabled by defining IMEM_ARB_STATS_EN.
module imem_port_arb #(
  parameter int IMEM_W       = 13,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_port_arb_if.slave    bus,
  output logic [IMEM_W-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1,
  output logic [CNT_W-1:0]  gnt_cnt2,
  output logic [CNT_W-1:0]  starve_cnt
`endif
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || CNT_W < 1) begin : g_bad_param
    $error("imem_port_arb: STARVE_LIMIT must be 1..15 and CNT_W >= 1");
  end

  localparam logic [3:0]        LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [IMEM_W-1:0] WORD_MSK = ~IMEM_W'(3);

  logic [3:0]        r_wait1;
  logic [3:0]        r_wait2;
  logic              r_last_p1;
  logic [2:0]        r_rvalid;
  logic [31:0]       r_rdata;

  logic              w_p1;
  logic              w_p2;
  logic              w_promo;
  logic [2:0]        w_gnt;
  logic [IMEM_W-1:0] w_addr;

  function automatic logic [3:0] next_wait(input logic [3:0] cur, input logic rq,
                                           input logic g);
    if (!rq || g)        return '0;
    else if (cur == '1)  return cur;
    else                 return cur + 4'd1;
  endfunction

  always_comb begin
    w_p1    = (r_wait1 >= LIMIT) && bus.req[1];
    w_p2    = (r_wait2 >= LIMIT) && bus.req[2];
    w_promo = 1'b0;
    w_gnt   = '0;
    if (!rst_n) begin
      w_gnt = '0;
    end else if (w_p1 && w_p2) begin
      // Both aged out: alternate, using who took the last promoted grant.
      w_promo = 1'b1;
      w_gnt   = r_last_p1 ? 3'b100 : 3'b010;
    end else if (w_p1) begin
      w_promo = 1'b1;
      w_gnt   = 3'b010;
    end else if (w_p2) begin
      w_promo = 1'b1;
      w_gnt   = 3'b100;
    end else if (bus.req[0]) begin
      w_gnt = 3'b001;
    end else if (bus.req[1]) begin
      w_gnt = 3'b010;
    end else if (bus.req[2]) begin
      w_gnt = 3'b100;
    end
  end

  always_comb begin
    w_addr = '0;
    unique case (w_gnt)
      3'b001:  w_addr = bus.addr0;
      3'b010:  w_addr = bus.addr1;
      3'b100:  w_addr = bus.addr2;
      default: w_addr = '0;
    endcase
  end

  assign mem_raddr   = w_addr & WORD_MSK;
  assign bus.gnt     = w_gnt;
  assign bus.rvalid  = r_rvalid;
  assign bus.rdata   = r_rdata;
  assign bus.starved = {w_p2, w_p1, 1'b0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait1   <= '0;
      r_wait2   <= '0;
      r_last_p1 <= 1'b0;
      r_rvalid  <= '0;
      r_rdata   <= '0;
    end else begin
      r_rvalid <= w_gnt;
      if (|w_gnt) r_rdata <= mem_rdata;
      r_wait1 <= next_wait(r_wait1, bus.req[1], w_gnt[1]);
      r_wait2 <= next_wait(r_wait2, bus.req[2], w_gnt[2]);
      if (w_promo) r_last_p1 <= w_gnt[1];
    end
  end

`ifdef IMEM_ARB_STATS_EN
  logic [CNT_W-1:0] r_gnt_cnt0;
  logic [CNT_W-1:0] r_gnt_cnt1;
  logic [CNT_W-1:0] r_gnt_cnt2;
  logic [CNT_W-1:0] r_starve_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cur, input logic en);
    if (en && (cur != '1)) return cur + CNT_W'(1);
    else                   return cur;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gnt_cnt0   <= '0;
      r_gnt_cnt1   <= '0;
      r_gnt_cnt2   <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_gnt_cnt0   <= sat_inc(r_gnt_cnt0, w_gnt[0]);
      r_gnt_cnt1   <= sat_inc(r_gnt_cnt1, w_gnt[1]);
      r_gnt_cnt2   <= sat_inc(r_gnt_cnt2, w_gnt[2]);
      r_starve_cnt <= sat_inc(r_starve_cnt, w_promo);
    end
  end

  assign gnt_cnt0   = r_gnt_cnt0;
  assign gnt_cnt1   = r_gnt_cnt1;
  assign gnt_cnt2   = r_gnt_cnt2;
  assign starve_cnt = r_starve_cnt;
`endif

endmodule

// File: tb/tb_imem_port_arb.sv
// Scoreboard bench for imem_port_arb: a rule-level arbitration model predicts
// grants and read responses; a negedge monitor compares them against the DUT.
module tb_imem_port_arb;
  localparam int IMEM_W = 13;
  localparam int LIMIT  = 4;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [IMEM_W-1:0] mem_raddr;
  logic [31:0]       mem_rdata;
  logic [31:0]       mem [0:2047];
  assign mem_rdata = mem[mem_raddr[IMEM_W-1:2]];

  imem_port_arb_if #(.IMEM_W(IMEM_W)) bus();

`ifdef IMEM_ARB_STATS_EN
  logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1, gnt_cnt2, starve_cnt;
`endif

  imem_port_arb #(.IMEM_W(IMEM_W), .STARVE_LIMIT(LIMIT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
`ifdef IMEM_ARB_STATS_EN
    ,
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1),
    .gnt_cnt2  (gnt_cnt2),
    .starve_cnt(starve_cnt)
`endif
  );

  typedef struct {
    int                c;
    logic [2:0]        gnt;
    logic [IMEM_W-1:0] raddr;
    logic [2:0]        starved;
    bit                rchk;
  } comb_t;

  typedef struct {
    int          due;
    logic [2:0]  rv;
    logic [31:0] rd;
  } rd_t;

  comb_t qc[$];
  rd_t   qr[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  int mw[3];
  int mlast = 0;
  int mg[3];
  int mscnt = 0;
  bit prev_rst = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit rst, input logic [2:0] r, input logic [IMEM_W-1:0] a0,
                      input logic [IMEM_W-1:0] a1, input logic [IMEM_W-1:0] a2,
                      output int g);
    bit                p1, p2;
    logic [IMEM_W-1:0] ga;
    comb_t             ce;
    rd_t               re;
    @(posedge clk);
    #1;
    rst_n     = rst;
    bus.req   = r;
    bus.addr0 = a0;
    bus.addr1 = a1;
    bus.addr2 = a2;

    p1 = (mw[1] >= LIMIT) && r[1];
    p2 = (mw[2] >= LIMIT) && r[2];
    g  = -1;
    if (rst) begin
      if (p1 && p2)  g = (mlast == 1) ? 2 : 1;
      else if (p1)   g = 1;
      else if (p2)   g = 2;
      else if (r[0]) g = 0;
      else if (r[1]) g = 1;
      else if (r[2]) g = 2;
    end
    ga = (g == 0) ? a0 : (g == 1) ? a1 : (g == 2) ? a2 : '0;
    ce.c       = cyc;
    ce.gnt     = (g < 0) ? 3'b000 : 3'(1 << g);
    ce.raddr   = {ga[IMEM_W-1:2], 2'b00};
    ce.starved = {p2, p1, 1'b0};
    ce.rchk    = !prev_rst;
    qc.push_back(ce);
    if (g >= 0) begin
      re.due = cyc + 1;
      re.rv  = 3'(1 << g);
      re.rd  = mem[ga[IMEM_W-1:2]];
      qr.push_back(re);
    end

    if (!rst) begin
      mw = '{0, 0, 0};
      mg = '{0, 0, 0};
      mlast = 0;
      mscnt = 0;
    end else begin
      for (int i = 1; i < 3; i++)
        mw[i] = (r[i] && g != i) ? ((mw[i] < 15) ? mw[i] + 1 : 15) : 0;
      if (g > 0 && (p1 || p2)) begin
        mlast = g;
        mscnt++;
      end
      if (g >= 0) mg[g]++;
    end
    prev_rst = rst;
  endtask

  always @(negedge clk) begin : monitor
    comb_t e;
    rd_t   r;
    if (qc.size() > 0 && qc[0].c == cyc) begin
      e = qc.pop_front();
      check("gnt", 32'(bus.gnt), 32'(e.gnt));
      check("mem_raddr", 32'(mem_raddr), 32'(e.raddr));
      check("starved", 32'(bus.starved), 32'(e.starved));
      check("gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
      if (e.rchk) begin
        check("reset_rvalid", 32'(bus.rvalid), 32'd0);
        check("reset_rdata", bus.rdata, 32'd0);
      end
      while (qr.size() > 0 && qr[0].due < cyc) begin
        r = qr.pop_front();
        check("rvalid_missing", 32'd0, 32'(r.rv));
      end
      if (qr.size() > 0 && qr[0].due == cyc) begin
        r = qr.pop_front();
        check("rvalid", 32'(bus.rvalid), 32'(r.rv));
        check("rdata", bus.rdata, r.rd);
      end else if (!e.rchk) begin
        check("rvalid_idle", 32'(bus.rvalid), 32'd0);
      end
    end
  end

  initial begin
    int               g;
    bit               pend[3];
    logic [IMEM_W-1:0] pa[3];
    logic [2:0]       rv;

    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    mem[13'h104 >> 2] = 32'h00A00093;
    bus.req = '0; bus.addr0 = '0; bus.addr1 = '0; bus.addr2 = '0;
    mw = '{0, 0, 0};
    mg = '{0, 0, 0};

    // reset held with all requests up
    for (int i = 0; i < 3; i++) step(1'b0, 3'b111, 13'h10, 13'h20, 13'h30, g);
    step(1'b1, 3'b000, '0, '0, '0, g);
    // single fetch, then misaligned requester 1
    step(1'b1, 3'b001, 13'h0104, 13'h0, 13'h0, g);
    step(1'b1, 3'b000, '0, '0, '0, g);
    step(1'b1, 3'b010, 13'h0, 13'h0107, 13'h0, g);
    step(1'b1, 3'b000, '0, '0, '0, g);
    // grant followed by mid-operation reset, then aging
    step(1'b1, 3'b001, 13'h0200, 13'h0, 13'h0, g);
    step(1'b0, 3'b011, 13'h0300, 13'h0400, 13'h0, g);
    for (int i = 0; i < 6; i++) step(1'b1, 3'b011, 13'h0300, 13'h0404, 13'h0, g);
    step(1'b1, 3'b000, '0, '0, '0, g);
`ifdef IMEM_ARB_STATS_EN
    check("aging_gnt_cnt1", 32'(gnt_cnt1), 32'd1);
    check("aging_starve_cnt", 32'(starve_cnt), 32'd1);
    check("aging_gnt_cnt0", 32'(gnt_cnt0), 32'(mg[0]));
`endif
    // both aged out: alternate promoted grants
    for (int i = 0; i < 12; i++) step(1'b1, 3'b111, 13'h0500, 13'h0604, 13'h0709, g);
    step(1'b1, 3'b000, '0, '0, '0, g);
    // requester 2 drops after 3 denied cycles, then re-requests
    for (int i = 0; i < 3; i++) step(1'b1, 3'b101, 13'h0800, 13'h0, 13'h0900, g);
    step(1'b1, 3'b001, 13'h0800, 13'h0, 13'h0900, g);
    for (int i = 0; i < 6; i++) step(1'b1, 3'b101, 13'h0800, 13'h0, 13'h0904, g);
    step(1'b1, 3'b000, '0, '0, '0, g);

    // randomized traffic obeying hold-until-grant, with occasional drops and resets
    pend = '{0, 0, 0};
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            pend[i] = 1'b1;
            pa[i]   = IMEM_W'($urandom_range(0, 8191));
          end
        end else if ($urandom_range(0, 9) == 0) begin
          pend[i] = 1'b0;
        end
      end
      rv = {pend[2], pend[1], pend[0]};
      step(($urandom_range(0, 99) != 0), rv, pa[0], pa[1], pa[2], g);
      if (g >= 0) pend[g] = 1'b0;
    end
    step(1'b1, 3'b000, '0, '0, '0, g);
    step(1'b1, 3'b000, '0, '0, '0, g);
`ifdef IMEM_ARB_STATS_EN
    check("final_gnt_cnt0", 32'(gnt_cnt0), 32'(mg[0]));
    check("final_gnt_cnt1", 32'(gnt_cnt1), 32'(mg[1]));
    check("final_gnt_cnt2", 32'(gnt_cnt2), 32'(mg[2]));
    check("final_starve_cnt", 32'(starve_cnt), 32'(mscnt));
`endif
    @(negedge clk);
    #1;
    check("pending_responses", 32'(qr.size()), 32'd0);
    check("pending_cycles", 32'(qc.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_port_arb.md
Name: imem_port_arb

Overview:
- Shares the single combinational read port of the instruction memory between three requesters:
  - instruction fetch (requester 0)
  - load/store unit reading constants from the text region (requester 1)
  - debug/trace reader (requester 2)
- Fixed priority with aging: fetch normally wins, and lower requesters are guaranteed service after a bounded wait.
- Read data is registered, so every requester sees a one-cycle req/gnt -> rvalid response.

Parameters:
- IMEM_W, 13: byte-address width of the instruction memory port.
- STARVE_LIMIT, 4: consecutive denied cycles after which a waiting requester 1 or 2 is promoted above fetch (range 1..15).
- CNT_W, 16: width of the grant counters (optional feature only).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  3  per-requester read request; bit i = requester i.
- addr0/addr1/addr2  in  IMEM_W each  byte address per requester; bits [1:0] ignored.
- gnt  out  3  one-hot grant, combinational, same cycle as the accepted req.
- rvalid  out  3  one-hot, asserted the cycle after the grant.
- rdata  out  32  registered read word; valid only while any rvalid bit is high.
- mem_raddr  out  IMEM_W  address driven to the instruction memory; equals the granted requester's addr with bits [1:0] forced to 0, else 0.
- mem_rdata  in  32  combinational instruction memory read data.
- starved  out  3  per-requester flag: aging promotion active this cycle (bit 0 always 0).

Behaviour:
- Reset (rst_n low at a clock edge):
  - rvalid=0, rdata=0, wait counters=0, last_gnt=0, stats counters=0.
  - gnt and mem_raddr are 0 while rst_n is low, regardless of req.
- Handshake:
  - A requester holds req and its addr stable until it sees gnt.
  - Grant completes the transfer; deasserting req before gnt is allowed and drops the request.
  - Dropping a request clears that requester's wait counter.
- Arbitration (combinational, per cycle):
  - If requester 1 or 2 has wait counter >= STARVE_LIMIT and req high, it wins.
  - If both qualify, requester 1 wins; when requester 1 won the previous promoted grant (last_gnt), requester 2 wins. This alternates the two.
  - Otherwise fixed priority: 0 > 1 > 2.
  - At most one gnt bit is high. No req means gnt=0 and mem_raddr=0.
- Wait counters (requesters 1 and 2, 4 bits each):
  - Increment when req is high and gnt is low.
  - Saturate at 15.
  - Clear on grant or when req is low.
- Data path:
  - On the grant edge: rdata <= mem_rdata, and rvalid <= gnt.
  - With no grant, rvalid returns to 0 and rdata holds its value.
- Throughput and latency:
  - One grant per cycle, back-to-back allowed.
  - Latency is exactly 1 cycle from gnt to rvalid.
- starved[i] = (wait_i >= STARVE_LIMIT) & req[i].
- Reset mid-operation:
  - A grant in the reset cycle produces no rvalid.
  - Pending requests must be re-presented after reset.
- Address wrap: no range check; addr is used modulo 2^IMEM_W.

Optional Feature:
- Macro: IMEM_ARB_STATS_EN.
- When defined:
  - Adds outputs gnt_cnt0/gnt_cnt1/gnt_cnt2 (CNT_W each) and starve_cnt (CNT_W).
  - gnt_cnt* increment on each grant to that requester; starve_cnt increments on each promoted grant.
  - All counters saturate at all-ones and reset to 0.
- When undefined: those ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with req=3'b111 for 3 cycles -> gnt=0, rvalid=0, rdata=0, mem_raddr=0 throughout.
- Single fetch read:
  - Stimulus: req=3'b001, addr0=0x0104, memory word 0x00A00093 at 0x0104.
  - Response: gnt=3'b001 and mem_raddr=0x104 in the same cycle; next cycle rvalid=3'b001, rdata=0x00A00093.
- Misaligned address: req=3'b010, addr1=0x0107 -> mem_raddr=0x0104; rdata next cycle equals the word at 0x0104.
- Aging with STARVE_LIMIT=4: req[0] and req[1] held high continuously from cycle 0.
  - Cycles 0-3: gnt=3'b001.
  - Cycle 4: starved[1]=1 and gnt=3'b010.
  - Cycle 5: fetch again.
- Both starved: req=3'b111 held for 12 cycles.
  - Promoted grants alternate between requester 1 and requester 2, with fetch grants between them.
  - gnt is never multi-hot.
- Dropped request and stats: requester 2 waits 3 cycles, then deasserts req.
  - Its wait counter returns to 0 and no grant is issued.
  - With IMEM_ARB_STATS_EN, after the aging test gnt_cnt1=1 and starve_cnt=1.
